huffman_bit_packer: RTL and testbench
=====================================

Name: huffman_bit_packer

Overview:
Downstream neighbour of the Huffman encoder. Accepts variable-length codewords (up to 16 bits, right-aligned, with an explicit length) and packs them MSB-first into a contiguous byte stream for the output interface or FIFO. It provides a valid/ready handshake on both sides and a flush command that zero-pads and emits the final partial byte at end of block.

Parameters:
MAX_LEN, 16, maximum codeword length in bits; code_in width.
ACC_W, 32, bit-accumulator width; must be at least 2*MAX_LEN.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
enable  input  1  block enable; low freezes all state.
code_valid  input  1  codeword on code_in/code_len is valid.
code_ready  output  1  packer can accept a codeword this cycle.
code_in  input  16  codeword, right-aligned; bits above code_len are ignored.
code_len  input  5  codeword length 0..16; 17..31 treated as 16.
flush  input  1  one-cycle request: pad and emit the remaining bits.
flush_done  output  1  one-cycle pulse when the flush is complete.
out_valid  output  1  out_data holds a packed byte.
out_ready  input  1  consumer accepts the byte.
out_data  output  8  packed byte; first-received bit is at bit 7.
byte_count  output  16  total bytes emitted since reset; wraps at 0xFFFF->0.

Behaviour:
- Reset (rst=0, async): acc=0, count=0, FSM=RUN, code_ready=0, out_valid=0, out_data=0, flush_done=0, byte_count=0.
- Accumulator acc[ACC_W-1:0] holds valid bits MSB-aligned in acc[31 -: count]. All bits below the valid region are always 0.
- Outputs are functions of registers only; there is no combinational path from inputs to outputs.
- FSM states:
  - RUN: normal operation.
  - DRAIN: a flush is pending and input is blocked.
  - PAD: the partial byte is padded.
  - DONE: flush_done is asserted.
- code_ready = enable and FSM==RUN and count <= ACC_W-MAX_LEN (16).
- out_valid = enable and count >= 8. out_data = acc[31:24].
- Pop: out_valid and out_ready. Shift acc left by 8, count -= 8, byte_count += 1.
- Push: code_valid and code_ready. Mask code_in to len bits, place it at acc bit position (31 - count_after_pop) downward, count += len.
- Pop and push in the same cycle: the pop shift is applied first, then the codeword is appended at count-8. The new count is count-8+len.
- code_len=0 push: accepted, no effect on acc or count.
- Latency: a pushed codeword that completes a byte makes out_valid high on the next cycle.
- Flush sequence:
  - flush sampled high in RUN: go to DRAIN; code_ready goes low. A push on that same cycle is still accepted.
  - DRAIN: pop normally. When count<8: if count>0, go to PAD; if count==0, go to DONE.
  - PAD: count := 8. The padding zeros are already present. Go to DRAIN, which emits the padded byte, then reaches count==0 and goes to DONE.
  - DONE: flush_done=1 for one cycle, then return to RUN.
- flush asserted outside RUN is ignored.
- flush with count==0: flush_done is asserted two cycles later (RUN -> DRAIN -> DONE); no byte is emitted.
- enable=0: code_ready=0, out_valid=0, flush_done=0. acc, count, FSM and byte_count are held. An enable=0 cycle does not count toward any latency.
- out_ready low: the byte is held stable. Pushes continue until count > 16.
- Full: count in 17..32 blocks input. count never exceeds 32.
- Reset mid-operation: all bits are discarded immediately. No flush_done is asserted.

Test Plan:
- Reset, enable=1, push (0b101, len 3) then (0b11001, len 5), out_ready=1 -> one byte 0xB9; byte_count=1; count returns to 0.
- Push (0xA55A, len 16), out_ready=1 -> bytes 0xA5 then 0x5A on consecutive cycles; byte_count=2.
- Push (0b11, len 2), then pulse flush -> byte 0xC0; flush_done pulses once after the byte handshake; code_ready low during the flush and high again afterwards.
- out_ready=0, push (0xFFFF, len 16) three times -> first two accepted, code_ready=0 on the third (count=32). Release out_ready -> four 0xFF bytes; the third push is accepted once count<=16.
- Simultaneous pop and push: count=8 (0x3C pending), push (0xF, len 4) with out_ready=1 -> 0x3C emitted, count=4. Then flush -> 0xF0, flush_done.
- Mid-stream rst low with count=12 -> all outputs 0 immediately. After release, push (0x00FF, len 8) -> 0xFF, byte_count=1.

Source files
------------

// File: rtl/huffman_bit_packer.sv
// Packs right-aligned variable-length codewords MSB-first into a byte stream.
// Enable is registered so that every output depends on registers only.
module huffman_bit_packer #(
    parameter int MAX_LEN = 16,
    parameter int ACC_W   = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_code_valid,
    output logic               o_code_ready,
    input  logic [MAX_LEN-1:0] i_code_in,
    input  logic [4:0]         i_code_len,
    input  logic               i_flush,
    output logic               o_flush_done,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [7:0]         o_out_data,
    output logic [15:0]        o_byte_count
);

    localparam int CNT_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_PAD,
        S_DONE
    } state_t;

    logic             r_en;
    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_byte_count;

    state_t           w_state_next;
    logic [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0] w_count_next;
    logic [ACC_W-1:0] w_acc_popped;
    logic [CNT_W-1:0] w_count_popped;
    logic [ACC_W-1:0] w_code_aligned;
    logic [MAX_LEN-1:0] w_code_masked;
    logic [4:0]       w_len;
    logic [4:0]       w_pad_shift;
    logic             w_pop;
    logic             w_push;

    assign o_code_ready = r_en && (r_state == S_RUN) && (r_count <= CNT_W'(ACC_W - MAX_LEN));
    assign o_out_valid  = r_en && (r_count >= CNT_W'(8));
    assign o_out_data   = r_acc[ACC_W-1 -: 8];
    assign o_flush_done = r_en && (r_state == S_DONE);
    assign o_byte_count = r_byte_count;

    assign w_pop  = o_out_valid && i_out_ready;
    assign w_push = i_code_valid && o_code_ready;

    assign w_len       = (i_code_len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : i_code_len;
    assign w_pad_shift = 5'(MAX_LEN) - w_len;

    // Bits above the codeword length are don't-care on the input and must not leak in.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign w_code_masked[gi] = i_code_in[gi] & (5'(gi) < w_len);
        end
    endgenerate

    always_comb begin
        w_acc_popped   = w_pop ? (r_acc << 8) : r_acc;
        w_count_popped = w_pop ? (r_count - CNT_W'(8)) : r_count;
        // Left-justify the codeword at the top, then slide it below the surviving bits.
        w_code_aligned = ({w_code_masked, {(ACC_W - MAX_LEN){1'b0}}} << w_pad_shift) >> w_count_popped;
        w_acc_next     = w_push ? (w_acc_popped | w_code_aligned) : w_acc_popped;
        w_count_next   = w_push ? (w_count_popped + CNT_W'(w_len)) : w_count_popped;
        if (r_state == S_PAD) begin
            // Padding zeros already sit below the valid bits; just claim a full byte.
            w_count_next = CNT_W'(8);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN: begin
                if (i_flush) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_count < CNT_W'(8)) begin
                    w_state_next = (r_count != '0) ? S_PAD : S_DONE;
                end
            end
            S_PAD:   w_state_next = S_DRAIN;
            S_DONE:  w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en         <= 1'b0;
            r_state      <= S_RUN;
            r_acc        <= '0;
            r_count      <= '0;
            r_byte_count <= '0;
        end else begin
            r_en <= i_enable;
            if (r_en) begin
                r_state <= w_state_next;
                r_acc   <= w_acc_next;
                r_count <= w_count_next;
                if (w_pop) begin
                    r_byte_count <= r_byte_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Bench for huffman_bit_packer: bit-queue model feeds an expected-byte scoreboard,
// table-driven codeword vectors plus hand sequences for backpressure, flush and reset.
module tb_huffman_bit_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        code_valid;
    logic        code_ready;
    logic [15:0] code_in;
    logic [4:0]  code_len;
    logic        flush;
    logic        flush_done;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] byte_count;

    int compared = 0;
    int mismatched = 0;

    bit         bitq[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [15:0] code;
        logic [4:0]  len;
        bit          do_flush;
        int          exp_bc;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    huffman_bit_packer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_code_valid (code_valid),
        .o_code_ready (code_ready),
        .i_code_in    (code_in),
        .i_code_len   (code_len),
        .i_flush      (flush),
        .o_flush_done (flush_done),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_byte_count (byte_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_pack();
        logic [7:0] b;
        while (bitq.size() >= 8) begin
            for (int i = 0; i < 8; i++) b[7-i] = bitq.pop_front();
            exp_q.push_back(b);
        end
    endfunction

    function automatic void model_push(input logic [15:0] c, input logic [4:0] l);
        int n;
        n = (l > 5'd16) ? 16 : int'(l);
        for (int i = n - 1; i >= 0; i--) bitq.push_back(c[i]);
        model_pack();
    endfunction

    function automatic void model_flush();
        while ((bitq.size() % 8) != 0) bitq.push_back(1'b0);
        model_pack();
    endfunction

    // Scoreboard: every byte handshake is checked against the model's next byte.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_byte: got 0x%0h, expected none", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("out_byte", {24'd0, out_data}, {24'd0, e});
            end
            $display("byte 0x%02h byte_count_before=%0d", out_data, byte_count);
        end
    end

    // Entered and left one time unit after a rising edge.
    task automatic push(input logic [15:0] c, input logic [4:0] l);
        int n = 0;
        code_valid = 1'b1;
        code_in    = c;
        code_len   = l;
        @(negedge clk);
        while (!code_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!code_ready) begin
            compared++;
            mismatched++;
            $display("FAIL push_timeout: got code_ready=0, expected 1 within 200 cycles");
            @(posedge clk);
            #1 code_valid = 1'b0;
        end else begin
            model_push(c, l);
            $display("push code=0x%04h len=%0d", c, l);
            @(posedge clk);
            #1 code_valid = 1'b0;
        end
    endtask

    task automatic do_flush(output int lat);
        int pulses = 0;
        model_flush();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_blocks_input", {31'd0, code_ready}, 32'd0);
        lat = 1;
        while (!flush_done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!flush_done) begin
            compared++;
            mismatched++;
            $display("FAIL flush_timeout: got flush_done=0, expected 1 within 100 cycles");
        end else begin
            pulses++;
            check("flush_drained", exp_q.size(), 32'd0);
            @(negedge clk);
            if (flush_done) pulses++;
            check("flush_done_pulses", pulses, 32'd1);
            check("ready_after_flush", {31'd0, code_ready}, 32'd1);
        end
        $display("flush latency=%0d", lat);
        @(posedge clk);
        #1;
    endtask

    task automatic settle_check_bc(input string name, input int exp_bc);
        repeat (4) @(negedge clk);
        check(name, {16'd0, byte_count}, exp_bc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        vecs[0]  = '{16'h0005, 5'd3,  1'b0, 0, -1};
        vecs[1]  = '{16'h0019, 5'd5,  1'b0, 1, -1};
        vecs[2]  = '{16'hA55A, 5'd16, 1'b0, 3, -1};
        vecs[3]  = '{16'h0003, 5'd2,  1'b1, 4, -1};
        vecs[4]  = '{16'h1234, 5'd20, 1'b0, 6, -1};
        vecs[5]  = '{16'hFFFF, 5'd0,  1'b0, 6, -1};
        vecs[6]  = '{16'hFFF5, 5'd4,  1'b0, 6, -1};
        vecs[7]  = '{16'h0003, 5'd3,  1'b0, 6, -1};
        vecs[8]  = '{16'h0001, 5'd1,  1'b0, 7, -1};
        vecs[9]  = '{16'h0000, 5'd0,  1'b1, 7, 2};
        vecs[10] = '{16'h0007, 5'd3,  1'b1, 8, -1};
        vecs[11] = '{16'hFFFF, 5'd5,  1'b0, 8, -1};
        vecs[12] = '{16'h0000, 5'd3,  1'b0, 9, -1};

        rst_n = 1'b0; enable = 1'b1; code_valid = 1'b0; code_in = '0;
        code_len = '0; flush = 1'b0; out_ready = 1'b1;
        #3;
        check("rst_code_ready", {31'd0, code_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_flush_done", {31'd0, flush_done}, 32'd0);
        check("rst_byte_count", {16'd0, byte_count}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_reset", {31'd0, code_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 13; v++) begin
            push(vecs[v].code, vecs[v].len);
            if (vecs[v].do_flush) begin
                do_flush(lat);
                if (vecs[v].exp_lat >= 0) check("flush_empty_latency", lat, vecs[v].exp_lat);
            end
            settle_check_bc($sformatf("byte_count_vec%0d", v), vecs[v].exp_bc);
        end

        // Pop and push on the same edge: 0x3C leaves while 0xF joins.
        out_ready = 1'b0;
        push(16'h003C, 5'd8);
        out_ready = 1'b1;
        push(16'h000F, 5'd4);
        @(negedge clk);
        check("popush_no_byte_left", {31'd0, out_valid}, 32'd0);
        check("popush_ready", {31'd0, code_ready}, 32'd1);
        @(posedge clk);
        #1;
        do_flush(lat);
        settle_check_bc("byte_count_popush", 11);

        // Backpressure until full, then release.
        out_ready = 1'b0;
        push(16'hFFFF, 5'd16);
        push(16'hFFFF, 5'd16);
        fork
            push(16'hFFFF, 5'd16);
            begin
                repeat (3) @(negedge clk);
                check("full_blocks_input", {31'd0, code_ready}, 32'd0);
                check("full_out_valid", {31'd0, out_valid}, 32'd1);
                check("full_out_data", {24'd0, out_data}, 32'h0000_00FF);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        settle_check_bc("byte_count_full", 17);

        // Enable low freezes and blocks input.
        push(16'h0005, 5'd3);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("disabled_ready", {31'd0, code_ready}, 32'd0);
        check("disabled_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 enable = 1'b1;
        push(16'h001F, 5'd5);
        settle_check_bc("byte_count_enable", 18);

        // Reset mid-stream discards pending bits.
        out_ready = 1'b0;
        push(16'h0ABC, 5'd12);
        @(negedge clk);
        check("pending_out_data", {24'd0, out_data}, 32'h0000_00AB);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data", {24'd0, out_data}, 32'd0);
        check("midrst_byte_count", {16'd0, byte_count}, 32'd0);
        check("midrst_code_ready", {31'd0, code_ready}, 32'd0);
        bitq.delete();
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        push(16'h00FF, 5'd8);
        settle_check_bc("byte_count_after_reset", 1);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
